// File: rtl/seg7_scan_driver_if.sv
// Digit-select / segment-pattern bus between the scan driver and its mux.
// The driver is the master: it drives sel and reads back mux_data.
interface seg7_scan_driver_if;
  logic [2:0] sel;
  logic [7:0] mux_data;

  modport master (
    output sel,
    input  mux_data
  );

  modport slave (
    input  sel,
    output mux_data
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit seven-segment scan controller.
// Each slot opens with a blanking gap, then shows one digit.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [7:0]                 digit_mask,
  input  logic [7:0]                 blink_mask,
  input  logic                       blink_tick,
  seg7_scan_driver_if.master         mux,
  output logic [7:0]                 an,
  output logic [7:0]                 seg,
  output logic                       frame_done
);

  localparam logic [0:0] BLANK = 1'b0;
  localparam logic [0:0] SHOW  = 1'b1;

  localparam logic [15:0] PRE_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] PRE_CAP  = 16'(BLANK_CYC - 1);

  logic [15:0] pre_q, pre_d;
  logic [0:0]  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [7:0]  an_q, an_d;
  logic [7:0]  seg_q, seg_d;
  logic        fd_q, fd_d;
  logic        blink_q, blink_d;

  logic        last;
  logic        cap;
  logic        lit;
  logic [7:0]  an_word;

  assign last = (pre_q == PRE_LAST);
  assign cap  = (state_q == BLANK) && (pre_q == PRE_CAP);
  assign lit  = digit_mask[sel_q] &
                ~(blink_mask[sel_q] & blink_q);
  assign an_word = lit ? ~(8'h01 << sel_q) : 8'hFF;

  always_comb begin
    pre_d   = pre_q;
    state_d = state_q;
    sel_d   = sel_q;
    an_d    = an_q;
    seg_d   = seg_q;
    fd_d    = 1'b0;
    blink_d = blink_q ^ blink_tick;
    unique case (1'b1)
      (!en): begin
        pre_d   = '0;
        state_d = BLANK;
        an_d    = 8'hFF;
        seg_d   = 8'hFF;
      end
      (en && last): begin
        pre_d   = '0;
        sel_d   = sel_q + 3'd1;
        state_d = BLANK;
        an_d    = 8'hFF;
        fd_d    = (sel_q == 3'd7);
      end
      default: begin
        pre_d = pre_q + 16'd1;
        // anode turns on the same edge the pattern is captured
        if (cap) begin
          seg_d   = mux.mux_data;
          state_d = SHOW;
        end
        an_d = (cap || state_q == SHOW)
               ? an_word : 8'hFF;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= '0;
      state_q <= BLANK;
      sel_q   <= '0;
      an_q    <= 8'hFF;
      seg_q   <= 8'hFF;
      fd_q    <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      state_q <= state_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
      blink_q <= blink_d;
    end
  end

  assign mux.sel    = sel_q;
  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with SCAN_DIV=10, BLANK_CYC=2.
// Mux model returns C0+sel unless an override pattern is forced.
module tb_seg7_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic [7:0] digit_mask = 8'hFF;
  logic [7:0] blink_mask = 8'h00;
  logic       blink_tick = 1'b0;
  logic [7:0] an;
  logic [7:0] seg;
  logic       frame_done;

  logic       ovr = 1'b0;
  logic [7:0] ovr_val = 8'h00;

  int n_vec = 0;
  int n_err = 0;

  seg7_scan_driver_if mux_if ();

  assign mux_if.mux_data = ovr ? ovr_val
                         : (8'hC0 + {5'b0, mux_if.sel});

  seg7_scan_driver #(
    .SCAN_DIV  (10),
    .BLANK_CYC (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .digit_mask (digit_mask),
    .blink_mask (blink_mask),
    .blink_tick (blink_tick),
    .mux        (mux_if.master),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [7:0] on_word(input int s);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << s);
  endfunction

  initial begin
    int p;
    int s;
    logic [7:0] e_an;
    logic [7:0] e_seg;

    // reset state
    step();
    step();
    chk("rst_sel", {5'b0, mux_if.sel}, 8'h00);
    chk("rst_an", an, 8'hFF);
    chk("rst_seg", seg, 8'hFF);
    chk("rst_fd", {7'b0, frame_done}, 8'h00);
    rst_n = 1'b1;

    // frame 1 plain scan, frame 2 with digit 2 masked
    for (int i = 1; i <= 160; i++) begin
      if (i == 81) digit_mask = 8'hFB;
      step();
      p = i % 10;
      s = (i / 10) % 8;
      e_an = (p < 2) ? 8'hFF : on_word(s);
      if (i > 80 && s == 2) e_an = 8'hFF;
      if (p >= 2) e_seg = 8'(8'hC0 + s);
      else if (i < 10) e_seg = 8'hFF;
      else e_seg = 8'(8'hC0 + ((s + 7) % 8));
      chk("scan_sel", {5'b0, mux_if.sel}, 8'(s));
      chk("scan_an", an, e_an);
      chk("scan_seg", seg, e_seg);
      chk("scan_fd", {7'b0, frame_done},
          8'((i == 80 || i == 160) ? 1 : 0));
    end
    digit_mask = 8'hFF;
    blink_mask = 8'h01;

    // blink: digit 0 dark from cycle 165 until after second pulse
    for (int i = 161; i <= 249; i++) begin
      step();
      p = i % 10;
      s = (i / 10) % 8;
      e_an = (p < 2) ? 8'hFF : on_word(s);
      if (s == 0 && i >= 165 && i <= 246) e_an = 8'hFF;
      chk("blink_an", an, e_an);
      blink_tick = (i == 163 || i == 245);
    end
    blink_mask = 8'h00;

    // advance to pre=5 of slot 3
    for (int i = 250; i <= 275; i++) step();
    chk("pre_en_an", an, 8'hF7);
    chk("pre_en_sel", {5'b0, mux_if.sel}, 8'h03);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("en0_an", an, 8'hFF);
      chk("en0_seg", seg, 8'hFF);
      chk("en0_sel", {5'b0, mux_if.sel}, 8'h03);
    end
    en = 1'b1;

    // restart: full blank, 8 lit cycles, then slot 4
    for (int r = 1; r <= 22; r++) begin
      step();
      if (r == 1) begin
        chk("en1_an_blank", an, 8'hFF);
      end else if (r <= 9) begin
        chk("en1_an_lit", an, 8'hF7);
        chk("en1_seg", seg, 8'hC3);
        chk("en1_sel", {5'b0, mux_if.sel}, 8'h03);
      end else if (r == 10) begin
        chk("en1_sel_next", {5'b0, mux_if.sel}, 8'h04);
        chk("en1_an_next", an, 8'hFF);
      end else if (r == 11) begin
        chk("mux_seg_hold", seg, 8'hC3);
      end else if (r == 12) begin
        chk("mux_seg_cap", seg, 8'hC4);
        ovr_val = 8'h5A;
        ovr = 1'b1;
      end else if (r < 22) begin
        chk("mux_seg_kept", seg, 8'hC4);
      end else begin
        chk("mux_seg_new", seg, 8'h5A);
        ovr = 1'b0;
      end
    end

    // asynchronous reset at pre=6 of slot 5
    for (int r = 23; r <= 26; r++) step();
    chk("prerst_an", an, 8'hDF);
    chk("prerst_sel", {5'b0, mux_if.sel}, 8'h05);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_an", an, 8'hFF);
    chk("arst_seg", seg, 8'hFF);
    chk("arst_sel", {5'b0, mux_if.sel}, 8'h00);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_an_blank", an, 8'hFF);
    chk("rel_sel", {5'b0, mux_if.sel}, 8'h00);
    step();
    chk("rel_an_lit", an, 8'hFE);
    chk("rel_seg", seg, 8'hC0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed 8-digit seven-segment scan controller.
- Drives the 3-bit select of the 8-way 8-bit segment-pattern mux and consumes its output.
- Registers the selected pattern onto the segment lines and drives the matching anode.
- Inserts a blanking gap between digits (anti-ghosting) and supports per-digit enable and blink.

Parameters:
SCAN_DIV, 16, clock cycles per digit slot; legal range BLANK_CYC+2 to 65535.
BLANK_CYC, 2, cycles at the start of each slot with all anodes off; legal range 1 to SCAN_DIV-2.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable.
digit_mask  input  8  bit i = 1: digit i may light.
blink_mask  input  8  bit i = 1: digit i is dark while blink_phase = 1.
blink_tick  input  1  one-cycle pulse; toggles blink_phase.
mux_data  input  8  segment pattern from the mux, active-low, bit7 = dp.
sel  output  3  digit select to the mux s input.
an  output  8  anodes, active-low, one-hot-low or all high.
seg  output  8  registered segments, active-low.
frame_done  output  1  one-cycle pulse when sel wraps 7 to 0.

Behaviour:
- Reset, asynchronous on rst_n low:
  - sel = 0, an = 8'hFF, seg = 8'hFF, frame_done = 0.
  - blink_phase = 0, prescaler pre = 0, state = BLANK.
- pre counts 0 to SCAN_DIV-1 while en = 1, then wraps to 0.
- All outputs are registered.
- State BLANK (pre < BLANK_CYC):
  - an = 8'hFF; sel holds the current digit.
  - On the edge where pre == BLANK_CYC-1: seg <= mux_data and state goes to SHOW.
  - sel is stable at least BLANK_CYC cycles before capture, so the mux is combinational-safe.
- State SHOW (BLANK_CYC <= pre <= SCAN_DIV-1):
  - Each cycle, an[i] <= 0 only for i == sel, digit_mask[sel] = 1, and NOT (blink_mask[sel] & blink_phase). All other an bits are 1.
  - Mask and blink changes are visible in an one cycle later. seg is not recaptured within the slot.
- Slot end, on the edge where pre == SCAN_DIV-1:
  - sel <= sel+1 mod 8, pre <= 0, state <= BLANK, an <= 8'hFF.
  - Same edge, if sel was 7: frame_done <= 1 for exactly one cycle, aligned with sel = 0.
- Slot timing, relative to slot start: an is high for BLANK_CYC cycles, then low for SCAN_DIV-BLANK_CYC cycles. A frame is 8*SCAN_DIV cycles.
- blink_tick:
  - Toggles blink_phase on any cycle, including while en = 0.
  - Takes effect on an the cycle after the toggle.
- en = 0:
  - Next edge: an = 8'hFF, seg = 8'hFF, pre = 0, state = BLANK, frame_done = 0.
  - sel holds.
  - When en returns to 1, the slot restarts from BLANK on the held sel. The full blank is enforced; there is no partial slot.
- digit_mask[sel] = 0 for a slot: an stays 8'hFF, seg is still captured, timing is unchanged.
- Never more than one an bit low. Anodes never assert during BLANK, so there is no overlap between adjacent digits.
- Mid-operation reset: all outputs return to reset values immediately, without waiting for a clock edge.

Test Plan:
1. Bench configuration: SCAN_DIV = 10, BLANK_CYC = 2. Release rst_n, en = 1, all masks 8'hFF, blink_mask = 0, mux model returns 8'hC0+sel.
   - Required: sel steps 0..7 every 10 cycles.
   - Each slot: an = FF for 2 cycles, then ~(1<<sel) for 8 cycles, with seg = C0+sel.
   - frame_done pulses once every 80 cycles, in the cycle sel becomes 0.
2. digit_mask = 8'b1111_1011.
   - Required: an stays FF throughout slot 2; other slots are unchanged; slot length is still 10 cycles.
3. blink_mask = 8'h01, blink_tick pulse mid-slot 0.
   - Required: an returns to FF the cycle after the pulse and stays dark for digit 0 on later frames.
   - A second pulse restores it.
4. en dropped at pre = 5 of slot 3 for 4 cycles, then raised.
   - Required: an = FF and seg = FF the cycle after en falls; sel stays 3.
   - After en rises: full 2-cycle blank, then digit 3 lights for 8 cycles, then sel = 4.
5. rst_n asserted at pre = 6 of slot 5.
   - Required: an = FF, seg = FF, sel = 0 asynchronously.
   - After release, the scan restarts at slot 0 with a blank phase.
6. Changing mux_data during the SHOW phase of the current slot.
   - Required: seg holds the value captured at pre = 1 and only updates at the next slot's capture.
